// File: rtl/seq_match_ctrl.sv
// Run controller: serializes upstream bytes MSB first into a programmable
// 1..MAXLEN-bit pattern matcher, counts matches and stops at a programmed limit.
module seq_match_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              hit,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

    state_t            state_q;
    logic [MAXLEN-1:0] pat_q;
    logic [LEN_W-1:0]  len_q;
    logic              ovl_q;
    logic [CNT_W-1:0]  limit_q;
    logic [MAXLEN-1:0] window_q, window_d;
    logic [LEN_W-1:0]  fill_q, fill_d;
    logic [7:0]        byte_q;
    logic [2:0]        bidx_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, hit_q, busy_q, done_q;

    logic [MAXLEN-1:0] len_mask;
    logic [LEN_W-1:0]  len_clamped;
    logic              is_match, lim_hit;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAXLEN))
            len_clamped = LEN_W'(MAXLEN);

        window_d = {window_q[MAXLEN-2:0], byte_q[bidx_q]};
        fill_d   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        len_mask = '0;
        for (int unsigned i = 0; i < MAXLEN; i++)
            len_mask[i] = (LEN_W'(i) < len_q);
        is_match = (state_q == S_SHIFT) && (fill_d == len_q) &&
                   (((window_d ^ pat_q) & len_mask) == '0);
        count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        lim_hit  = is_match && (limit_q != '0) && (count_d == limit_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            ovl_q      <= 1'b0;
            limit_q    <= '0;
            window_q   <= '0;
            fill_q     <= '0;
            byte_q     <= '0;
            bidx_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;

            // Datapath advances even under abort so a coincident match still counts.
            if (state_q == S_SHIFT) begin
                window_q <= window_d;
                fill_q   <= (is_match && !ovl_q) ? '0 : fill_d;
                bidx_q   <= bidx_q - 3'd1;
                if (is_match) begin
                    hit_q   <= 1'b1;
                    count_q <= count_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pat_q      <= cfg_pattern;
                        len_q      <= len_clamped;
                        ovl_q      <= cfg_overlap;
                        limit_q    <= cfg_limit;
                        window_q   <= '0;
                        fill_q     <= '0;
                        count_q    <= '0;
                        state_q    <= S_FETCH;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        byte_q     <= in_data;
                        bidx_q     <= 3'd7;
                        state_q    <= S_SHIFT;
                        in_ready_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (lim_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (bidx_q == 3'd0) begin
                        state_q    <= S_FETCH;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (abort) begin
                state_q    <= S_IDLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign hit         = hit_q;
    assign match_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed cases plus randomized runs checked
// against a bit-history queue model of the matcher.
module tb_seq_match_ctrl;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, cfg_overlap, in_valid;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]  cfg_len;
    logic [CNT_W-1:0]  cfg_limit;
    logic [7:0]        in_data;
    logic              in_ready, hit, busy, done;
    logic [CNT_W-1:0]  match_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [MAXLEN-1:0] m_pat;
    int                m_len;
    bit                m_ovl;
    int                m_lim;
    int                m_cnt;
    bit                hist[$];

    seq_match_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_limit(cfg_limit), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .hit(hit), .match_count(match_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Match = the last len bits seen since the run start (or the last
    // non-overlapping match) equal the pattern, oldest bit first.
    task automatic model_bit(input bit b, output bit mhit, output bit mlim);
        hist.push_back(b);
        if (hist.size() > m_len) void'(hist.pop_front());
        mhit = (hist.size() == m_len);
        for (int i = 0; i < m_len; i++)
            if (mhit && hist[i] != m_pat[m_len-1-i]) mhit = 0;
        mlim = 0;
        if (mhit) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_ovl) hist.delete();
            mlim = (m_lim != 0) && (m_cnt == m_lim);
        end
    endtask

    task automatic start_run(input int pat, input int len, input bit ovl, input int lim);
        cfg_pattern = MAXLEN'(pat);
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_limit   = CNT_W'(lim);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pat = MAXLEN'(pat);
        m_len = (len == 0) ? 1 : ((len > MAXLEN) ? MAXLEN : len);
        m_ovl = ovl;
        m_lim = lim;
        m_cnt = 0;
        hist.delete();
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_count", match_count, 0);
        // Config changes during a run must be ignored
        cfg_pattern = MAXLEN'($urandom);
        cfg_len     = LEN_W'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_limit   = CNT_W'($urandom);
    endtask

    task automatic end_run();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("end_ready", in_ready, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 0);
        check("end_count", match_count, m_cnt);
    endtask

    // abort_at: bit position (0..7) at which abort is raised, or -1 for none
    task automatic send_byte(input logic [7:0] b, input int gap, input int abort_at,
                             input bit rnd_start, output bit ended);
        bit mhit, mlim;
        ended = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start = rnd_start ? 1'($urandom) : 1'b0;
            tick();
            start = 1'b0;
            check("gap_ready", in_ready, 1);
            check("gap_hit", hit, 0);
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        check("acc_ready", in_ready, 0);
        check("acc_busy", busy, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) abort = 1'b1;
            start = rnd_start ? 1'($urandom) : 1'b0;
            tick();
            start = 1'b0;
            model_bit(b[7-k], mhit, mlim);
            check("bit_hit", hit, mhit);
            check("bit_count", match_count, m_cnt);
            if (k == abort_at) begin
                abort = 1'b0;
                check("abort_ready", in_ready, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                tick();
                check("abort_idle_count", match_count, m_cnt);
                check("abort_idle_hit", hit, 0);
                ended = 1;
                return;
            end
            if (mlim) begin
                check("lim_done", done, 1);
                check("lim_busy", busy, 0);
                check("lim_ready", in_ready, 0);
                tick();
                check("post_done", done, 0);
                check("post_busy", busy, 0);
                check("post_ready", in_ready, 0);
                check("post_hit", hit, 0);
                check("post_count", match_count, m_cnt);
                ended = 1;
                return;
            end
            check("bit_done", done, 0);
            check("bit_busy", busy, 1);
            check("bit_ready", in_ready, (k == 7) ? 1 : 0);
        end
    endtask

    initial begin
        bit ended;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = '0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_limit = '0;
        tick(); tick();
        check("rst_ready", in_ready, 0);
        check("rst_hit", hit, 0);
        check("rst_count", match_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // 1010 overlap, 0xAA -> 3 hits
        start_run(4'b1010, 4, 1, 0);
        send_byte(8'hAA, 0, -1, 0, ended);
        check("ovl_total", match_count, 3);
        end_run();

        // 1010 non-overlap -> 2 hits
        start_run(4'b1010, 4, 0, 0);
        send_byte(8'hAA, 1, -1, 0, ended);
        check("novl_total", match_count, 2);
        end_run();

        // limit 2 -> done after bit 6
        start_run(4'b1010, 4, 1, 2);
        send_byte(8'hAA, 0, -1, 0, ended);
        check("lim_ended", ended, 1);
        check("lim_total", match_count, 2);

        // match spanning a byte boundary with idle gaps
        start_run(4'b1010, 4, 1, 0);
        send_byte(8'h05, 3, -1, 0, ended);
        send_byte(8'h00, 3, -1, 0, ended);
        check("span_total", match_count, 1);
        end_run();

        // len 0 treated as 1
        start_run(1, 0, 1, 0);
        send_byte(8'hF0, 0, -1, 0, ended);
        check("len0_total", match_count, 4);
        end_run();

        // len 20 clamps to 8
        start_run(8'hA5, 20, 1, 0);
        send_byte(8'hA5, 0, -1, 0, ended);
        send_byte(8'hA5, 0, -1, 0, ended);
        check("clamp_total", match_count, 2);
        end_run();

        // abort mid-byte holds the count, no done
        start_run(4'b1010, 4, 1, 0);
        send_byte(8'hAA, 0, 5, 1, ended);
        check("abort_total", match_count, 2);

        // counter saturation
        start_run(1, 1, 1, 0);
        for (int i = 0; i < 33; i++) send_byte(8'hFF, 0, -1, 0, ended);
        check("sat_total", match_count, CNT_MAX);
        end_run();

        // reset mid-byte
        start_run(4'b1010, 4, 1, 0);
        in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mrst_ready", in_ready, 0);
        check("mrst_hit", hit, 0);
        check("mrst_count", match_count, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // randomized runs
        for (int r = 0; r < 60; r++) begin
            int nb, ab_byte, ab_bit, len, lim;
            len = $urandom_range(0, 20);
            lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 5);
            start_run(int'($urandom_range(0, 255)), len, 1'($urandom), lim);
            nb = $urandom_range(1, 6);
            ab_byte = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
            ab_bit  = $urandom_range(0, 7);
            ended = 0;
            for (int i = 0; i < nb && !ended; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 1) == 0) ? m_pat : 8'($urandom);
                send_byte(b, $urandom_range(0, 3), (i == ab_byte) ? ab_bit : -1, 1, ended);
            end
            if (!ended) end_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Run controller for the serial pattern-match path. It takes bytes from an upstream valid/ready source and serializes them MSB first into a programmable pattern matcher with a window of 1..MAXLEN bits. It supports overlapping and non-overlapping modes, counts matches, and ends a run after a programmed number of matches. It sits between the byte-stream source and the match/interrupt logic, and replaces hard-wired fixed-pattern detectors.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of the match counter and the limit.
- LEN_W, 5: width of cfg_len; must satisfy 2^LEN_W > MAXLEN.

- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begins a run when sampled in IDLE.
- abort  in  1  ends the run immediately; highest priority.
- cfg_pattern  in  MAXLEN  match pattern; bit [len-1] is the oldest bit, bit 0 the newest.
- cfg_len  in  LEN_W  pattern length; 0 is treated as 1 and values above MAXLEN as MAXLEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_limit  in  CNT_W  match count that ends the run; 0 = unlimited.
- in_data  in  8  byte from the source.
- in_valid  in  1  source has a byte.
- in_ready  out  1  controller accepts a byte this cycle.
- hit  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  matches in the current or last run.
- busy  out  1  high in FETCH and SHIFT.
- done  out  1  one-cycle pulse when the limit is reached.

## Operation
- States: IDLE, FETCH, SHIFT, DONE. Reset enters IDLE and clears all outputs and internal registers to 0.
- **IDLE**
  - On start: latch cfg_pattern, cfg_len (clamped), cfg_overlap and cfg_limit.
  - Clear the window, the fill counter and match_count, then go to FETCH.
  - Config changes during a run are ignored. start outside IDLE is ignored.
- **FETCH**
  - in_ready = 1.
  - On in_valid && in_ready: load in_data into the byte shifter, set bit index to 7, go to SHIFT.
- **SHIFT** (one bit per cycle, MSB first)
  - Update window as {window[MAXLEN-2:0], bit}.
  - Update fill as min(fill+1, len).
  - A match is true when the new fill equals len and new window[len-1:0] equals pattern[len-1:0].
  - On a match: hit = 1 and match_count increments, saturating at all-ones.
  - On a match with non-overlap mode: fill returns to 0.
  - On a match with overlap mode: fill is unchanged.
  - When bit index 0 has shifted (and the limit is not reached), go to FETCH.
- Window and fill carry over between bytes, so a match can span a byte boundary.
- Limit: if cfg_limit != 0 and match_count reaches cfg_limit on this edge, go to DONE. Remaining bits of the current byte are discarded.
- **DONE**: done = 1 for one cycle, then IDLE. match_count holds until the next start.
- **abort** (any state): go to IDLE on the next edge. No done pulse is generated. match_count holds. abort in the same cycle as a match: hit still pulses and the count still updates.
- in_ready = 0 in IDLE, SHIFT and DONE.

## Timing
- start edge → FETCH; in_ready is high in the next cycle.
- Byte accept edge → first bit shifted on the following edge. 8 SHIFT cycles per byte, plus at least 1 FETCH cycle, gives at most one byte every 9 cycles.
- hit and match_count are registered. Both become visible in the cycle after the edge that shifts in the completing bit.
- done is high in the cycle after the limit-reaching match, i.e. concurrent with the last hit.
- busy is high in the same cycle as the new state; it is 0 in DONE.
- rst_n low at any edge overrides everything, including abort and start.

## Test plan
- Pattern 4'b1010, len 4, overlap 1, limit 0, byte 0xAA → hits after bits 4, 6 and 8; match_count = 3; returns to FETCH.
- Same with overlap 0 → hits after bits 4 and 8; match_count = 2.
- Overlap 1, limit 2, byte 0xAA → done pulses after bit 6; match_count = 2; bits 7-8 are discarded; IDLE; in_ready stays 0.
- Bytes 0x05 then 0x00, pattern 1010, len 4, with idle gaps of 3 cycles between bytes (in_valid held low) → exactly one hit, on bit 1 of the second byte; match_count = 1.
- Boundary cases:
  - cfg_len = 0, pattern bit 0 = 1, byte 0xF0 → 4 hits.
  - cfg_len = 20 clamps to MAXLEN.
  - Counter saturation with CNT_W = 2, limit 0 → count holds at 3.
- Control cases:
  - start while busy → ignored.
  - abort during SHIFT → IDLE next cycle, no done, count held.
  - rst_n low mid-byte → all outputs 0 and IDLE on the next edge.
